// File: rtl/data_mem_mmio_if.sv
// Memory-stage bus between the core and the data memory / MMIO block.
// The master is the core side; the slave is data_mem_mmio.
interface data_mem_mmio_if #(
    parameter int LED_W = 8
);
    logic             MemWriteM;
    logic [31:0]      ALUResultM;
    logic [31:0]      WriteDataM;
    logic [31:0]      ReadDataM;
    logic [LED_W-1:0] leds;
    logic             timer_irq;

    modport master (
        output MemWriteM, ALUResultM, WriteDataM,
        input  ReadDataM, leds, timer_irq
    );

    modport slave (
        input  MemWriteM, ALUResultM, WriteDataM,
        output ReadDataM, leds, timer_irq
    );
endinterface

// File: rtl/data_mem_mmio.sv
// Data RAM plus MMIO bank (LEDs, free-running cycle counter, compare timer with IRQ).
// Loads are combinational; stores and register writes land on the rising edge.
module data_mem_mmio #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] MMIO_BASE = 32'h0000_1000,
    parameter int          LED_W     = 8
) (
    input logic            clk,
    input logic            reset,
    data_mem_mmio_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [2:0] REG_LED   = 3'd0;
    localparam logic [2:0] REG_CYCLE = 3'd1;
    localparam logic [2:0] REG_CMP   = 3'd2;
    localparam logic [2:0] REG_CTRL  = 3'd3;
    localparam logic [2:0] REG_CNT   = 3'd4;

    logic              ramHit;
    logic              mmioHit;
    logic [IDX_W-1:0]  ramIdx;
    logic [2:0]        regSel;
    logic              wrRam;
    logic              wrMmio;
    logic              wrLed;
    logic              wrCmp;
    logic              wrCtrl;
    logic              wrCnt;
    logic              timerMatch;
    logic              unusedAddrBits;

    logic [31:0]       mem [DEPTH];
    logic [LED_W-1:0]  ledReg;
    logic [31:0]       cycleCnt;
    logic [31:0]       tmrCmp;
    logic [31:0]       tmrCnt;
    logic              tmrEn;
    logic              tmrAuto;
    logic              tmrFlag;
    logic [31:0]       readData;

    // Word access only: the byte offset within a word never affects decode.
    assign unusedAddrBits = ^bus.ALUResultM[1:0];

    assign ramHit  = (bus.ALUResultM[31:IDX_W+2] == '0);
    assign mmioHit = (bus.ALUResultM[31:5] == MMIO_BASE[31:5]);
    assign ramIdx  = bus.ALUResultM[IDX_W+1:2];
    assign regSel  = bus.ALUResultM[4:2];

    assign wrRam  = bus.MemWriteM && ramHit && !reset;
    assign wrMmio = bus.MemWriteM && mmioHit && !ramHit;
    assign wrLed  = wrMmio && (regSel == REG_LED);
    assign wrCmp  = wrMmio && (regSel == REG_CMP);
    assign wrCtrl = wrMmio && (regSel == REG_CTRL);
    assign wrCnt  = wrMmio && (regSel == REG_CNT);

    assign timerMatch = tmrEn && (tmrCnt == tmrCmp);

    always_ff @(posedge clk) begin
        if (wrRam) begin
            mem[ramIdx] <= bus.WriteDataM;
        end
    end

    // Software writes follow the timer update so they override reload/one-shot;
    // a W1C is dropped when it collides with a match so the set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            ledReg   <= '0;
            cycleCnt <= '0;
            tmrCmp   <= '0;
            tmrCnt   <= '0;
            tmrEn    <= 1'b0;
            tmrAuto  <= 1'b0;
            tmrFlag  <= 1'b0;
        end else begin
            cycleCnt <= cycleCnt + 32'd1;
            if (timerMatch) begin
                tmrFlag <= 1'b1;
                if (tmrAuto) begin
                    tmrCnt <= '0;
                end else begin
                    tmrEn <= 1'b0;
                end
            end else if (tmrEn) begin
                tmrCnt <= tmrCnt + 32'd1;
            end

            if (wrLed) begin
                ledReg <= bus.WriteDataM[LED_W-1:0];
            end
            if (wrCmp) begin
                tmrCmp <= bus.WriteDataM;
            end
            if (wrCtrl) begin
                tmrEn   <= bus.WriteDataM[0];
                tmrAuto <= bus.WriteDataM[2];
                if (bus.WriteDataM[1] && !timerMatch) begin
                    tmrFlag <= 1'b0;
                end
            end
            if (wrCnt) begin
                tmrCnt <= bus.WriteDataM;
            end
        end
    end

    always_comb begin
        readData = '0;
        if (ramHit) begin
            readData = mem[ramIdx];
        end else if (mmioHit) begin
            case (regSel)
                REG_LED:   readData = 32'(ledReg);
                REG_CYCLE: readData = cycleCnt;
                REG_CMP:   readData = tmrCmp;
                REG_CTRL:  readData = {29'd0, tmrAuto, tmrFlag, tmrEn};
                REG_CNT:   readData = tmrCnt;
                default:   readData = '0;
            endcase
        end
    end

    assign bus.ReadDataM = readData;
    assign bus.leds      = ledReg;
    assign bus.timer_irq = tmrFlag;
endmodule
